// File: rtl/frac_divider_seq.sv
// Sequential restoring fractional divider: quotient = floor(dividend * 2^FRAC_BITS / divisor).
// Optional FRAC_DIV_ROUND_EN computes one guard bit and rounds to nearest.
module frac_divider_seq #(
  parameter int WIDTH_IN  = 7,
  parameter int FRAC_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH_IN-1:0]  dividend,
  input  logic [WIDTH_IN-1:0]  divisor,
  output logic                 busy,
  output logic                 done,
  output logic [FRAC_BITS-1:0] quotient,
  output logic                 div_zero,
  output logic                 ovf
);

`ifdef FRAC_DIV_ROUND_EN
  localparam int ITER = FRAC_BITS + 1;
`else
  localparam int ITER = FRAC_BITS;
`endif
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]           state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [WIDTH_IN:0]    rem_reg, rem_next;
  logic [WIDTH_IN-1:0]  div_reg, div_next;
  logic [ITER-1:0]      shift_reg, shift_next;
  logic                 err_zero_reg, err_zero_next;
  logic                 err_ovf_reg, err_ovf_next;
  logic [FRAC_BITS-1:0] quotient_reg, quotient_next;
  logic                 div_zero_reg, div_zero_next;
  logic                 ovf_reg, ovf_next;
  logic                 done_reg, done_next;

  // One restoring step; rem < divisor always holds, so the shift never loses a bit.
  logic [WIDTH_IN:0] rem_shift;
  logic [WIDTH_IN:0] div_ext;
  logic [WIDTH_IN:0] rem_sub;
  logic              q_bit;

  assign rem_shift = rem_reg << 1;
  assign div_ext   = {1'b0, div_reg};
  assign q_bit     = (rem_shift >= div_ext);
  assign rem_sub   = rem_shift - div_ext;

  logic [ITER-1:0] shift_in;
  assign shift_in[0] = q_bit;

  genvar gi;
  generate
    for (gi = 1; gi < ITER; gi++) begin : g_shift
      assign shift_in[gi] = shift_reg[gi-1];
    end
  endgenerate

  logic [FRAC_BITS-1:0] result;
`ifdef FRAC_DIV_ROUND_EN
  // Guard bit is the LSB of the extended result; a carry out saturates.
  logic [FRAC_BITS:0] round_sum;
  assign round_sum = {1'b0, shift_in[ITER-1:1]} + {{FRAC_BITS{1'b0}}, shift_in[0]};
  assign result    = round_sum[FRAC_BITS] ? {FRAC_BITS{1'b1}} : round_sum[FRAC_BITS-1:0];
`else
  assign result = shift_in;
`endif

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rem_next      = rem_reg;
    div_next      = div_reg;
    shift_next    = shift_reg;
    err_zero_next = err_zero_reg;
    err_ovf_next  = err_ovf_reg;
    quotient_next = quotient_reg;
    div_zero_next = div_zero_reg;
    ovf_next      = ovf_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = RUN;
          cnt_next      = '0;
          rem_next      = {1'b0, dividend};
          div_next      = divisor;
          shift_next    = '0;
          err_zero_next = (divisor == '0);
          err_ovf_next  = (divisor != '0) && (dividend >= divisor);
        end
      end
      RUN: begin
        if (err_zero_reg || err_ovf_reg) begin
          // Error operations skip iteration and report on the next edge.
          state_next    = IDLE;
          cnt_next      = '0;
          quotient_next = {FRAC_BITS{1'b1}};
          div_zero_next = err_zero_reg;
          ovf_next      = err_ovf_reg;
          done_next     = 1'b1;
        end else begin
          rem_next   = q_bit ? rem_sub : rem_shift;
          shift_next = shift_in;
          if (cnt_reg == CNT_LAST) begin
            state_next    = IDLE;
            cnt_next      = '0;
            quotient_next = result;
            div_zero_next = 1'b0;
            ovf_next      = 1'b0;
            done_next     = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      div_reg      <= '0;
      shift_reg    <= '0;
      err_zero_reg <= 1'b0;
      err_ovf_reg  <= 1'b0;
      quotient_reg <= '0;
      div_zero_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rem_reg      <= rem_next;
      div_reg      <= div_next;
      shift_reg    <= shift_next;
      err_zero_reg <= err_zero_next;
      err_ovf_reg  <= err_ovf_next;
      quotient_reg <= quotient_next;
      div_zero_reg <= div_zero_next;
      ovf_reg      <= ovf_next;
      done_reg     <= done_next;
    end
  end

  assign busy     = (state_reg == RUN);
  assign done     = done_reg;
  assign quotient = quotient_reg;
  assign div_zero = div_zero_reg;
  assign ovf      = ovf_reg;

endmodule

// File: doc/frac_divider_seq.md
Name: frac_divider_seq

Overview:
- Parametrised sequential fractional divider. It computes quotient = floor(dividend * 2^FRAC_BITS / divisor) for dividend < divisor, producing one bit per clock by restoring division.
- Successor to the fixed 7-bit / 8-cycle divider, which needed an external cycle counter. This block owns its iteration counter and adds a start/busy/done handshake, generic widths, and error flags.
- Sits in the interpolation datapath. It turns a pixel-distance ratio into a fixed-point weight.

Parameters:
- WIDTH_IN, 7, bit width of dividend and divisor.
- FRAC_BITS, 8, number of quotient fraction bits; also the number of iteration cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled only when busy=0.
- dividend  input  WIDTH_IN  numerator, unsigned.
- divisor  input  WIDTH_IN  denominator, unsigned.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when quotient is updated.
- quotient  output  FRAC_BITS  fractional result, unsigned 0.FRAC_BITS format; held until next done.
- div_zero  output  1  last completed operation had divisor==0; held with quotient.
- ovf  output  1  last completed operation had dividend>=divisor; held with quotient.

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, remainder=0, busy=0, done=0, quotient=0, div_zero=0, ovf=0. An operation in flight is discarded. No done is issued for it.
- States:
  - IDLE: start=1 at an edge -> capture operands, go to RUN; otherwise stay.
  - RUN: iterate until the last bit is computed, then go to IDLE while asserting done.
  - The done cycle is itself an IDLE cycle.
- Operands are captured at the accept edge (edge 0). Later changes to dividend/divisor have no effect.
- Remainder register is WIDTH_IN+1 bits wide. It loads the dividend at edge 0.
- At each edge k=1..N: rem2 = rem<<1; if rem2 >= divisor then rem = rem2 - divisor and bit=1, else rem = rem2 and bit=0. Bits are shifted into the quotient shift register MSB-first.
- N = FRAC_BITS. The counter is $clog2(N+1) bits and wraps to 0 on completion.
- Latency: at edge N, quotient, div_zero and ovf update, done rises for exactly one cycle, and busy falls. busy is high from edge 0 through edge N.
- Error cases (decided at edge 0, no iteration):
  - divisor==0: at edge 1, quotient = all ones, div_zero=1, ovf=0, done=1.
  - dividend>=divisor with divisor!=0: at edge 1, quotient = all ones (saturated), ovf=1, div_zero=0, done=1.
- A normal completion clears div_zero and ovf.
- start while busy=1 is ignored; no queuing.
- start in the done cycle (busy=0) is accepted, so back-to-back throughput is one result per N+1 cycles.
- quotient, div_zero and ovf change only on a done edge or on reset.

Optional Feature:
- Macro: FRAC_DIV_ROUND_EN.
- Defined:
  - Compute N = FRAC_BITS+1 bits, then round to nearest: quotient = upper FRAC_BITS bits + guard bit.
  - Saturate to all ones on carry-out.
  - Latency is FRAC_BITS+1 edges.
  - Error-case latency is unchanged (edge 1).
- Undefined: truncation; latency FRAC_BITS edges.

Test Plan:
- Default params, start with 13/27 -> busy high for edges 0..8, done pulse at edge 8, quotient=123 (0x7B), div_zero=0, ovf=0.
- Sweep dividend 0..26 over divisor 27, back-to-back starts issued in each done cycle:
  - one done every 9 cycles;
  - 0/27=0, 1/27=9, 26/27=246 (truncated);
  - with FRAC_DIV_ROUND_EN: 26/27=247, 2/3=171, 1/27=9, done every 10 cycles.
- Error cases:
  - 5/0 -> done at edge 1, quotient=0xFF, div_zero=1.
  - 30/27 and 27/27 -> done at edge 1, quotient=0xFF, ovf=1.
  - A following 1/3 -> quotient=85 with both flags cleared.
- Handshake robustness:
  - start re-asserted and operands changed during RUN of 13/27 -> ignored, result still 123, single done.
- Reset mid-operation:
  - rst low at edge 4 of 13/27 -> all outputs 0 immediately (async), no done.
  - After release, new 2/3 -> 170 at edge 8.
- Parameter override WIDTH_IN=10, FRAC_BITS=12: 500/1000 -> quotient=2048 (0x800), done at edge 12.
